motor_cmd_sequencer: RTL and testbench
======================================

MOTOR_CMD_SEQUENCER -- requirements
Module: motor_cmd_sequencer

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 50, stop-dwell length in clk_100 cycles before a direction reversal (1..65535).
REQ-002 SHALL have parameter RAMP_CYCLES, default 100, minimum run time in cycles before speed 2 is allowed (1..65535).
REQ-003 SHALL have parameter WDOG_CYCLES, default 200, number of command-free cycles in a run state that trips the watchdog (1..65535).
REQ-004 SHALL have port clk_100  input  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port rx_data  input  8  command byte from the Bluetooth UART receiver.
REQ-007 SHALL have port rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle only.
REQ-008 SHALL have port choose  output  2  00 = stop, 01 = forward, 10 = reverse.
REQ-009 SHALL have port speed  output  2  00 = off, 01 = speed 1, 10 = speed 2.
REQ-010 SHALL have port dir  output  3  011 = straight, 010 = right 1, 001 = right 2, 101 = left 1, 110 = left 2.
REQ-011 SHALL have port busy  output  1  high while in BRAKE.
REQ-012 SHALL have port cmd_err  output  1  one-cycle pulse on an unrecognised byte.
REQ-013 SHALL have port wdog_trip  output  1  one-cycle pulse when the watchdog forces a stop.

Function
REQ-014 SHALL register all outputs; a command accepted at edge N SHALL be visible on outputs after edge N.
REQ-015 SHALL implement the states IDLE, RUN_FWD, RUN_REV and BRAKE.
REQ-016 SHALL decode 0xA1/A3/A4/A6 as steer commands: dir <= 010/101/001/110 respectively in any state except BRAKE, with no state change.
REQ-017 SHALL, on 0xA2 in IDLE or RUN_FWD: enter RUN_FWD, choose=01, speed=01, dir=011, clear the ramp counter, clear boost_pending.
REQ-018 SHALL, on 0xA7 in IDLE or RUN_REV: enter RUN_REV, with choose=10 and otherwise identical to REQ-017.
REQ-019 SHALL, on 0xA7 in RUN_FWD or 0xA2 in RUN_REV: enter BRAKE, choose=00, speed=00, dir=011, and latch the target direction.
REQ-020 SHALL, in BRAKE: count DWELL_CYCLES cycles, then enter the latched run state as in REQ-017/018.
REQ-021 SHALL, on 0xA2/0xA7 during BRAKE: overwrite the latched target without restarting the dwell count.
REQ-022 SHALL ignore steer commands and 0xA8 during BRAKE.
REQ-023 SHALL, on 0xA5 in any state: enter IDLE next cycle with choose=00 and speed=00, dir unchanged, cancelling any pending reversal or boost.
REQ-024 SHALL, on 0xA8 in a run state: set speed=10 immediately if the ramp counter is >= RAMP_CYCLES; otherwise set boost_pending and apply speed=10 in the cycle the counter reaches RAMP_CYCLES.
REQ-025 SHALL ignore 0xA8 in IDLE.
REQ-026 SHALL saturate the ramp counter at RAMP_CYCLES; it SHALL count only in run states.
REQ-027 SHALL, for any other byte with rx_valid=1: pulse cmd_err for one cycle with no other effect.
REQ-028 SHALL ignore rx_data while rx_valid=0.

Reset
REQ-029 SHALL, on rst=1 and regardless of clock: state=IDLE, choose=00, speed=00, dir=011, busy=0, cmd_err=0, wdog_trip=0, all counters and pending flags cleared.
REQ-030 SHALL abandon a reset asserted mid-BRAKE or mid-ramp without resuming; the first command after deassertion is treated as from IDLE.

Configuration
REQ-031 SHALL, when macro MOTOR_WATCHDOG_EN is defined: count cycles in RUN_FWD/RUN_REV, clear the count on every recognised command, and on reaching WDOG_CYCLES enter IDLE (as 0xA5) and pulse wdog_trip.
REQ-032 SHALL, when MOTOR_WATCHDOG_EN is undefined: omit the watchdog counter, tie wdog_trip to 0, and never leave a run state except by command or reset.
REQ-033 SHALL, under MOTOR_WATCHDOG_EN, not clear the watchdog count on unrecognised bytes.

Verification
REQ-034 SHALL verify: reset, then 0xA2 -> next cycle choose=01, speed=01, dir=011, busy=0.
REQ-035 SHALL verify: RUN_FWD, then 0xA7 -> choose=00, busy=1 for exactly 50 cycles, then choose=10, speed=01.
REQ-036 SHALL verify: 0xA2, 0xA8 at cycle 10 -> speed stays 01 until ramp count reaches 100, then speed=10; a second 0xA8 after that -> speed=10 on the next cycle.
REQ-037 SHALL verify: mid-BRAKE 0xA5 -> IDLE next cycle, no reversal, busy=0.
REQ-038 SHALL verify: byte 0x3C -> cmd_err high for 1 cycle, outputs unchanged.
REQ-039 SHALL verify, with MOTOR_WATCHDOG_EN: 0xA2, then 200 idle cycles -> wdog_trip pulse, choose=00; without the macro, outputs are unchanged after 1000 cycles.

Source files
------------

// File: rtl/motor_cmd_sequencer.sv
// motor_cmd_sequencer
//   Decodes command bytes from the Bluetooth UART receiver into motor drive
//   controls. Direction reversals pass through a timed BRAKE dwell. A speed-2
//   request is held back until the motor has been running long enough.
//
// Parameters
//   DWELL_CYCLES : stop-dwell length before a reversal (1..65535)
//   RAMP_CYCLES  : minimum run time before speed 2 is allowed (1..65535)
//   WDOG_CYCLES  : command-free run cycles that trip the watchdog (1..65535)
//
// Ports
//   clk_100   in   system clock, rising-edge active
//   rst       in   asynchronous active-high reset
//   rx_data   in   [7:0] command byte
//   rx_valid  in   one-cycle strobe qualifying rx_data
//   choose    out  [1:0] 00 stop, 01 forward, 10 reverse
//   speed     out  [1:0] 00 off, 01 speed 1, 10 speed 2
//   dir       out  [2:0] 011 straight, 010/001 right 1/2, 101/110 left 1/2
//   busy      out  high while braking before a reversal
//   cmd_err   out  one-cycle pulse on an unrecognised byte
//   wdog_trip out  one-cycle pulse when the watchdog forces a stop
//
// Build option
//   MOTOR_WATCHDOG_EN : when defined, a run state with no recognised command
//                       for WDOG_CYCLES cycles drops back to IDLE. When it is
//                       not defined, wdog_trip is held at 0.

module motor_cmd_sequencer #(
  parameter int DWELL_CYCLES = 50,
  parameter int RAMP_CYCLES  = 100,
  parameter int WDOG_CYCLES  = 200
) (
  input  logic       clk_100,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [1:0] choose,
  output logic [1:0] speed,
  output logic [2:0] dir,
  output logic       busy,
  output logic       cmd_err,
  output logic       wdog_trip
);

  localparam logic [15:0] DWELL_C = 16'(DWELL_CYCLES);
  localparam logic [15:0] RAMP_C  = 16'(RAMP_CYCLES);

  localparam logic [1:0] CH_STOP = 2'b00;
  localparam logic [1:0] CH_FWD  = 2'b01;
  localparam logic [1:0] CH_REV  = 2'b10;
  localparam logic [1:0] SP_OFF  = 2'b00;
  localparam logic [1:0] SP_1    = 2'b01;
  localparam logic [1:0] SP_2    = 2'b10;
  localparam logic [2:0] DIR_STRAIGHT = 3'b011;

  typedef enum logic [1:0] {IDLE, RUN_FWD, RUN_REV, BRAKE} state_t;

  state_t      state;
  logic        tgt_rev;        // run direction to enter once the dwell ends
  logic        boost_pending;  // speed-2 requested before the ramp completed
  logic [15:0] ramp_cnt;
  logic [15:0] dwell_cnt;

  // Command decode; every flag is qualified by rx_valid.
  logic       is_fwd, is_rev, is_stop, is_boost, is_steer, is_known;
  logic [2:0] steer_dir;

  always_comb begin
    is_fwd    = 1'b0;
    is_rev    = 1'b0;
    is_stop   = 1'b0;
    is_boost  = 1'b0;
    is_steer  = 1'b0;
    steer_dir = DIR_STRAIGHT;
    if (rx_valid) begin
      case (rx_data)
        8'hA1: begin is_steer = 1'b1; steer_dir = 3'b010; end
        8'hA3: begin is_steer = 1'b1; steer_dir = 3'b101; end
        8'hA4: begin is_steer = 1'b1; steer_dir = 3'b001; end
        8'hA6: begin is_steer = 1'b1; steer_dir = 3'b110; end
        8'hA2: is_fwd   = 1'b1;
        8'hA7: is_rev   = 1'b1;
        8'hA5: is_stop  = 1'b1;
        8'hA8: is_boost = 1'b1;
        default: ;
      endcase
    end
    is_known = is_fwd | is_rev | is_stop | is_boost | is_steer;
  end

  logic        in_run;
  logic [15:0] ramp_inc;
  logic        ramp_due;   // counter is at, or reaches at this edge, RAMP_CYCLES
  logic        dwell_done;
  logic        tgt_rev_nxt;

  assign in_run      = (state == RUN_FWD) || (state == RUN_REV);
  assign ramp_inc    = (ramp_cnt < RAMP_C) ? ramp_cnt + 16'd1 : ramp_cnt;
  assign ramp_due    = (ramp_inc >= RAMP_C);
  assign dwell_done  = (dwell_cnt == DWELL_C - 16'd1);
  // A direction command in the very cycle the dwell ends still wins.
  assign tgt_rev_nxt = is_rev ? 1'b1 : (is_fwd ? 1'b0 : tgt_rev);

  logic wdog_fire;

`ifdef MOTOR_WATCHDOG_EN
  localparam logic [15:0] WDOG_C = 16'(WDOG_CYCLES);

  logic [15:0] wdog_cnt;

  // Unrecognised bytes deliberately do not feed the watchdog.
  assign wdog_fire = in_run && !is_known && (wdog_cnt == WDOG_C - 16'd1);

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      wdog_cnt  <= 16'd0;
      wdog_trip <= 1'b0;
    end else begin
      wdog_trip <= wdog_fire;
      if (!in_run || is_known || wdog_fire)
        wdog_cnt <= 16'd0;
      else
        wdog_cnt <= wdog_cnt + 16'd1;
    end
  end
`else
  logic unused_wdog;

  assign unused_wdog = ^(16'(WDOG_CYCLES));
  assign wdog_fire   = 1'b0;
  assign wdog_trip   = 1'b0;
`endif

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      choose        <= CH_STOP;
      speed         <= SP_OFF;
      dir           <= DIR_STRAIGHT;
      busy          <= 1'b0;
      cmd_err       <= 1'b0;
      tgt_rev       <= 1'b0;
      boost_pending <= 1'b0;
      ramp_cnt      <= 16'd0;
      dwell_cnt     <= 16'd0;
    end else begin
      cmd_err <= rx_valid & ~is_known;

      if (wdog_fire || is_stop) begin
        // Stop keeps the steering setting but drops any pending work.
        state         <= IDLE;
        choose        <= CH_STOP;
        speed         <= SP_OFF;
        busy          <= 1'b0;
        boost_pending <= 1'b0;
        ramp_cnt      <= 16'd0;
        dwell_cnt     <= 16'd0;
      end else begin
        case (state)
          IDLE: begin
            if (is_fwd || is_rev) begin
              state         <= is_rev ? RUN_REV : RUN_FWD;
              choose        <= is_rev ? CH_REV : CH_FWD;
              speed         <= SP_1;
              dir           <= DIR_STRAIGHT;
              ramp_cnt      <= 16'd0;
              boost_pending <= 1'b0;
            end else if (is_steer) begin
              dir <= steer_dir;
            end
          end

          RUN_FWD, RUN_REV: begin
            ramp_cnt <= ramp_inc;
            if (boost_pending && ramp_due) begin
              speed         <= SP_2;
              boost_pending <= 1'b0;
            end

            if ((is_fwd && state == RUN_FWD) || (is_rev && state == RUN_REV)) begin
              // Same-direction command restarts the run at speed 1.
              choose        <= is_rev ? CH_REV : CH_FWD;
              speed         <= SP_1;
              dir           <= DIR_STRAIGHT;
              ramp_cnt      <= 16'd0;
              boost_pending <= 1'b0;
            end else if (is_fwd || is_rev) begin
              state         <= BRAKE;
              choose        <= CH_STOP;
              speed         <= SP_OFF;
              dir           <= DIR_STRAIGHT;
              busy          <= 1'b1;
              tgt_rev       <= is_rev;
              dwell_cnt     <= 16'd0;
              ramp_cnt      <= 16'd0;
              boost_pending <= 1'b0;
            end else if (is_steer) begin
              dir <= steer_dir;
            end else if (is_boost) begin
              if (ramp_due)
                speed <= SP_2;
              else
                boost_pending <= 1'b1;
            end
          end

          BRAKE: begin
            tgt_rev <= tgt_rev_nxt;
            if (dwell_done) begin
              state         <= tgt_rev_nxt ? RUN_REV : RUN_FWD;
              choose        <= tgt_rev_nxt ? CH_REV : CH_FWD;
              speed         <= SP_1;
              dir           <= DIR_STRAIGHT;
              busy          <= 1'b0;
              ramp_cnt      <= 16'd0;
              boost_pending <= 1'b0;
              dwell_cnt     <= 16'd0;
            end else begin
              dwell_cnt <= dwell_cnt + 16'd1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Directed testbench for motor_cmd_sequencer with default parameters
// (dwell 50, ramp 100, watchdog 200). Inputs change on the falling edge and
// outputs are sampled on the falling edge following each rising edge.

module tb_motor_cmd_sequencer;

  logic       clk_100 = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [1:0] choose;
  logic [1:0] speed;
  logic [2:0] dir;
  logic       busy;
  logic       cmd_err;
  logic       wdog_trip;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_100 = ~clk_100;

  motor_cmd_sequencer dut (
    .clk_100  (clk_100),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .choose   (choose),
    .speed    (speed),
    .dir      (dir),
    .busy     (busy),
    .cmd_err  (cmd_err),
    .wdog_trip(wdog_trip)
  );

  // Present one byte for exactly one rising edge; returns at the falling
  // edge right after that edge. Caller must be sitting on a falling edge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk_100);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_100);
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (choose !== 2'b00) begin n_bad++; $display("FAIL reset_choose: got %b want 00", choose); end
    n_cmp++; if (speed !== 2'b00) begin n_bad++; $display("FAIL reset_speed: got %b want 00", speed); end
    n_cmp++; if (dir !== 3'b011) begin n_bad++; $display("FAIL reset_dir: got %b want 011", dir); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_err: got %b want 0", cmd_err); end
    n_cmp++; if (wdog_trip !== 1'b0) begin n_bad++; $display("FAIL reset_wdog: got %b want 0", wdog_trip); end
    @(negedge clk_100);
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_start_fwd;
    send(8'hA2);
    n_cmp++; if (choose !== 2'b01) begin n_bad++; $display("FAIL fwd_choose: got %b want 01", choose); end
    n_cmp++; if (speed !== 2'b01) begin n_bad++; $display("FAIL fwd_speed: got %b want 01", speed); end
    n_cmp++; if (dir !== 3'b011) begin n_bad++; $display("FAIL fwd_dir: got %b want 011", dir); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL fwd_busy: got %b want 0", busy); end
  endtask

  task automatic test_steer;
    logic [7:0] cmds [4] = '{8'hA1, 8'hA3, 8'hA4, 8'hA6};
    logic [2:0] exps [4] = '{3'b010, 3'b101, 3'b001, 3'b110};
    for (int i = 0; i < 4; i++) begin
      send(cmds[i]);
      n_cmp++; if (dir !== exps[i]) begin n_bad++; $display("FAIL steer_dir_%0d: got %b want %b", i, dir, exps[i]); end
      n_cmp++; if (choose !== 2'b01) begin n_bad++; $display("FAIL steer_choose_%0d: got %b want 01", i, choose); end
    end
    send(8'hA5);  // stop keeps dir 110
    n_cmp++; if (choose !== 2'b00) begin n_bad++; $display("FAIL stop_choose: got %b want 00", choose); end
    n_cmp++; if (dir !== 3'b110) begin n_bad++; $display("FAIL stop_dir: got %b want 110", dir); end
    send(8'hA1);  // steering allowed in IDLE
    n_cmp++; if (dir !== 3'b010) begin n_bad++; $display("FAIL idle_steer: got %b want 010", dir); end
    send(8'hA2);
    n_cmp++; if (dir !== 3'b011) begin n_bad++; $display("FAIL restart_dir: got %b want 011", dir); end
  endtask

  task automatic test_bad_byte;
    send(8'h3C);
    n_cmp++; if (cmd_err !== 1'b1) begin n_bad++; $display("FAIL bad_cmd_err: got %b want 1", cmd_err); end
    n_cmp++; if ({choose, speed, dir} !== 7'b01_01_011) begin n_bad++; $display("FAIL bad_outputs: got %b want 0101011", {choose, speed, dir}); end
    idle(1);
    n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL bad_cmd_err_len: got %b want 0", cmd_err); end
    // Stop byte without a strobe must be ignored.
    rx_data = 8'hA5;
    @(negedge clk_100);
    rx_data = 8'h00;
    n_cmp++; if (choose !== 2'b01) begin n_bad++; $display("FAIL no_valid: got %b want 01", choose); end
  endtask

  task automatic test_reversal;
    int k;
    send(8'hA7);
    n_cmp++; if (choose !== 2'b00) begin n_bad++; $display("FAIL rev_brake_choose: got %b want 00", choose); end
    n_cmp++; if (speed !== 2'b00) begin n_bad++; $display("FAIL rev_brake_speed: got %b want 00", speed); end
    k = (busy === 1'b1) ? 1 : 0;
    while (busy === 1'b1 && k < 200) begin
      @(negedge clk_100);
      if (busy === 1'b1) k++;
    end
    n_cmp++; if (k != 50) begin n_bad++; $display("FAIL rev_busy_cycles: got %0d want 50", k); end
    n_cmp++; if (choose !== 2'b10) begin n_bad++; $display("FAIL rev_choose: got %b want 10", choose); end
    n_cmp++; if (speed !== 2'b01) begin n_bad++; $display("FAIL rev_speed: got %b want 01", speed); end
  endtask

  task automatic test_brake_overwrite;
    int k;
    send(8'hA2);           // RUN_REV -> BRAKE toward forward, edge k=0
    send(8'hA1);           // k=1, ignored
    n_cmp++; if (dir !== 3'b011) begin n_bad++; $display("FAIL brake_steer: got %b want 011", dir); end
    send(8'hA8);           // k=2, ignored
    n_cmp++; if (speed !== 2'b00) begin n_bad++; $display("FAIL brake_boost: got %b want 00", speed); end
    idle(18);              // k=20
    send(8'hA7);           // k=21, retarget reverse
    k = 21;
    while (busy === 1'b1 && k < 300) begin
      @(negedge clk_100);
      k++;
    end
    n_cmp++; if (k != 50) begin n_bad++; $display("FAIL overwrite_dwell: got %0d want 50", k); end
    n_cmp++; if (choose !== 2'b10) begin n_bad++; $display("FAIL overwrite_choose: got %b want 10", choose); end
  endtask

  task automatic test_brake_abort;
    send(8'hA2);           // RUN_REV -> BRAKE
    idle(10);
    send(8'hA5);
    n_cmp++; if ({choose, speed, busy} !== 5'b00_00_0) begin n_bad++; $display("FAIL abort_now: got %b want 00000", {choose, speed, busy}); end
    idle(60);
    n_cmp++; if ({choose, busy} !== 3'b00_0) begin n_bad++; $display("FAIL abort_later: got %b want 000", {choose, busy}); end
  endtask

  task automatic test_boost;
    int k;
    send(8'hA8);           // ignored in IDLE
    n_cmp++; if ({choose, speed, cmd_err} !== 5'b00_00_0) begin n_bad++; $display("FAIL idle_boost: got %b want 00000", {choose, speed, cmd_err}); end
    send(8'hA2);           // edge 0
    idle(9);
    send(8'hA8);           // edge 10
    n_cmp++; if (speed !== 2'b01) begin n_bad++; $display("FAIL boost_early: got %b want 01", speed); end
    k = 10;
    while (speed !== 2'b10 && k < 300) begin
      @(negedge clk_100);
      k++;
    end
    n_cmp++; if (k != 100) begin n_bad++; $display("FAIL boost_edge: got %0d want 100", k); end
    send(8'hA2);           // restart: speed 1, ramp cleared
    n_cmp++; if (speed !== 2'b01) begin n_bad++; $display("FAIL boost_restart: got %b want 01", speed); end
    idle(105);
    n_cmp++; if (speed !== 2'b01) begin n_bad++; $display("FAIL boost_no_req: got %b want 01", speed); end
    send(8'hA8);
    n_cmp++; if (speed !== 2'b10) begin n_bad++; $display("FAIL boost_immediate: got %b want 10", speed); end
  endtask

  task automatic test_reset_mid_brake;
    send(8'hA7);           // RUN_FWD -> BRAKE
    idle(5);
    rst = 1'b1;
    #1;
    n_cmp++; if ({choose, speed, dir, busy} !== 8'b00_00_011_0) begin n_bad++; $display("FAIL async_rst: got %b want 00000110", {choose, speed, dir, busy}); end
    @(negedge clk_100);
    rst = 1'b0;
    idle(60);
    n_cmp++; if ({choose, busy} !== 3'b00_0) begin n_bad++; $display("FAIL rst_no_resume: got %b want 000", {choose, busy}); end
    send(8'hA7);           // from IDLE goes straight to reverse
    n_cmp++; if ({choose, speed, busy} !== 5'b10_01_0) begin n_bad++; $display("FAIL rst_first_cmd: got %b want 10010", {choose, speed, busy}); end
  endtask

  task automatic test_watchdog;
    int k;
    logic seen;
    send(8'hA5);
    send(8'hA2);
`ifdef MOTOR_WATCHDOG_EN
    k = 0;
    while (wdog_trip !== 1'b1 && k < 400) begin
      @(negedge clk_100);
      k++;
    end
    n_cmp++; if (k != 200) begin n_bad++; $display("FAIL wdog_edge: got %0d want 200", k); end
    n_cmp++; if (choose !== 2'b00) begin n_bad++; $display("FAIL wdog_choose: got %b want 00", choose); end
    idle(1);
    n_cmp++; if (wdog_trip !== 1'b0) begin n_bad++; $display("FAIL wdog_pulse: got %b want 0", wdog_trip); end
`else
    seen = 1'b0;
    k = 0;
    repeat (1000) begin
      @(negedge clk_100);
      k++;
      if (wdog_trip !== 1'b0) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL no_wdog_trip: got %b want 0", seen); end
    n_cmp++; if ({choose, speed, dir} !== 7'b01_01_011) begin n_bad++; $display("FAIL no_wdog_outputs after %0d: got %b want 0101011", k, {choose, speed, dir}); end
`endif
  endtask

  initial begin
    test_reset;
    test_start_fwd;
    test_steer;
    test_bad_byte;
    test_reversal;
    test_brake_overwrite;
    test_brake_abort;
    test_boost;
    test_reset_mid_brake;
    test_watchdog;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
